// File: rtl/tqvp_vga_capture.sv
// TinyVGA PMOD receiver: locks to hsync/vsync, measures line/frame timing, samples one pixel per frame.
// Optional VGA_CAP_GLITCH_FILTER_EN: syncs need 3 equal samples (pixels delayed to keep coordinates).
module tqvp_vga_capture #(
  parameter int HCNT_W = 12,
  parameter int VCNT_W = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_HTIME  = 6'h08;
  localparam logic [5:0] A_VTIME  = 6'h0C;
  localparam logic [5:0] A_CAPPOS = 6'h10;
  localparam logic [5:0] A_CAPDAT = 6'h14;
  localparam logic [HCNT_W-1:0] HMAX = '1;
  localparam logic [VCNT_W-1:0] VMAX = '1;

  typedef enum logic [1:0] {ST_OFF, ST_SEEK, ST_LOCKED} state_t;

  state_t              state, state_n;
  logic [3:0]          ctrl;
  logic [HCNT_W-1:0]   cap_x, hcnt, htotal, hsync_w;
  logic [VCNT_W-1:0]   cap_y, vcnt, vtotal, vsync_w;
  logic [7:0]          frame_cnt;
  logic                cap_valid, irq_pend;
  logic [5:0]          cap_data;
  logic [31:0]         rdata;

  logic wr, rd, wr_ctrl, wr_status, wr_cappos, rd_status;
  logic hs_raw, vs_raw, hs, vs, hs_d, vs_d;
  logic hs_lead, hs_trail, vs_lead, vs_trail;
  logic [5:0] pix_raw, pix;
  logic [HCNT_W-1:0] hcnt_inc;
  logic [VCNT_W-1:0] vcnt_nx;
  logic active, locked, cap_hit, cap_clr, irq_set, irq_clr;
  logic unused_din;

  assign wr        = (data_write_n != 2'b11);
  assign rd        = (data_read_n != 2'b11);
  assign wr_ctrl   = wr && (address == A_CTRL);
  assign wr_status = wr && (address == A_STATUS);
  assign wr_cappos = wr && (address == A_CAPPOS);
  assign rd_status = rd && (address == A_STATUS);
  assign unused_din = ^{data_in[31:16+VCNT_W], data_in[15:HCNT_W]};

  // Normalise so that 1 means "sync active"; pixel reordered to {B1,B0,G1,G0,R1,R0}.
  assign hs_raw  = ui_in[7] ^ ctrl[1];
  assign vs_raw  = ui_in[3] ^ ctrl[2];
  assign pix_raw = {ui_in[2], ui_in[6], ui_in[1], ui_in[5], ui_in[0], ui_in[4]};

`ifdef VGA_CAP_GLITCH_FILTER_EN
  logic [1:0] hs_hist, vs_hist;
  logic [5:0] pix_d1, pix_d2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_hist <= '0;
      vs_hist <= '0;
      pix_d1  <= '0;
      pix_d2  <= '0;
    end else begin
      hs_hist <= {hs_hist[0], hs_raw};
      vs_hist <= {vs_hist[0], vs_raw};
      pix_d1  <= pix_raw;
      pix_d2  <= pix_d1;
    end
  end
  // hs_d doubles as the filter's held output: a new level is adopted only after three matching samples.
  assign hs  = (hs_hist == {2{hs_raw}}) ? hs_raw : hs_d;
  assign vs  = (vs_hist == {2{vs_raw}}) ? vs_raw : vs_d;
  assign pix = pix_d2;
`else
  assign hs  = hs_raw;
  assign vs  = vs_raw;
  assign pix = pix_raw;
`endif

  assign hs_lead  = hs & ~hs_d;
  assign hs_trail = ~hs & hs_d;
  assign vs_lead  = vs & ~vs_d;
  assign vs_trail = ~vs & vs_d;

  assign active   = (state != ST_OFF);
  assign locked   = (state == ST_LOCKED);
  assign hcnt_inc = (hcnt == HMAX) ? hcnt : hcnt + 1'b1;
  assign vcnt_nx  = (hs_lead && vcnt != VMAX) ? vcnt + 1'b1 : vcnt;

  assign cap_hit  = locked && (hcnt == cap_x) && (vcnt == cap_y) && !cap_valid;
  assign cap_clr  = (wr_status && data_in[1]) || wr_cappos;
  assign irq_set  = locked && vs_lead;
  assign irq_clr  = rd_status || (wr_status && data_in[2]);

  always_comb begin
    state_n = state;
    case (state)
      ST_OFF:    state_n = ST_SEEK;
      ST_SEEK:   if (vs_lead) state_n = ST_LOCKED;
      ST_LOCKED: if (hcnt == HMAX) state_n = ST_SEEK;
      default:   state_n = ST_OFF;
    endcase
    if (!ctrl[0]) state_n = ST_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      ctrl      <= 4'h6;
      cap_x     <= '0;
      cap_y     <= '0;
      hs_d      <= 1'b0;
      vs_d      <= 1'b0;
      hcnt      <= '0;
      vcnt      <= '0;
      htotal    <= '0;
      hsync_w   <= '0;
      vtotal    <= '0;
      vsync_w   <= '0;
      frame_cnt <= '0;
      irq_pend  <= 1'b0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      state <= state_n;
      hs_d  <= hs;
      vs_d  <= vs;
      if (wr_ctrl) ctrl <= data_in[3:0];
      if (wr_cappos) begin
        cap_x <= data_in[HCNT_W-1:0];
        cap_y <= data_in[16 +: VCNT_W];
      end
      if (!active) begin
        hcnt <= '0;
        vcnt <= '0;
      end else begin
        if (hs_lead) begin
          hcnt   <= '0;
          htotal <= hcnt_inc;
        end else begin
          hcnt <= hcnt_inc;
        end
        if (hs_trail) hsync_w <= hcnt_inc;
        // vs edges see the line count after any coincident hs increment.
        if (vs_lead) begin
          vcnt      <= '0;
          vtotal    <= vcnt_nx;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          vcnt <= vcnt_nx;
        end
        if (vs_trail) vsync_w <= vcnt_nx;
      end
      irq_pend <= irq_set | (irq_pend & ~irq_clr);
      if (cap_hit) cap_data <= pix;
      if (cap_clr) cap_valid <= 1'b0;
      else if (cap_hit) cap_valid <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      A_CTRL:   rdata[3:0] = ctrl;
      A_STATUS: rdata[15:0] = {frame_cnt, 5'd0, irq_pend, cap_valid, locked};
      A_HTIME: begin
        rdata[HCNT_W-1:0]  = htotal;
        rdata[16 +: HCNT_W] = hsync_w;
      end
      A_VTIME: begin
        rdata[VCNT_W-1:0]  = vtotal;
        rdata[16 +: VCNT_W] = vsync_w;
      end
      A_CAPPOS: begin
        rdata[HCNT_W-1:0]  = cap_x;
        rdata[16 +: VCNT_W] = cap_y;
      end
      A_CAPDAT: rdata[5:0] = cap_data;
      default:  rdata = '0;
    endcase
  end

  assign data_out       = rst_n ? rdata : 32'd0;
  assign data_ready     = 1'b1;
  assign uo_out         = 8'd0;
  assign user_interrupt = irq_pend & ctrl[3];

endmodule

// File: tb/tb_tqvp_vga_capture.sv
// Directed bench for tqvp_vga_capture: register table, line-timing table, then frame-level sequences.
module tb_tqvp_vga_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  tqvp_vga_capture dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  typedef struct { logic [5:0] addr; logic [31:0] exp; } rv_t;
  typedef struct { int ht; int hsw; bit pos; logic [3:0] ctrl; logic [31:0] exp; } tv_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus geometry; the pixel seen at CAP_X lands one clock after hcnt was cleared, hence cap_px = CAP_X + 1.
  int ht = 64, hsw = 8, vt = 20, vsw = 2;
  bit pospol = 1'b0;
  int cap_px = -1, cap_y = -1;
  logic [5:0] cap_col = 6'h2A;
  logic [5:0] bg_col  = 6'h15;
  bit glitch = 1'b0;
  int glitch_pos = 40;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pins(input bit ha, input bit va, input logic [5:0] c);
    logic h, v;
    h = pospol ? ha : ~ha;
    v = pospol ? va : ~va;
    return {h, c[4], c[2], c[0], v, c[5], c[3], c[1]};
  endfunction

  task automatic send_line(input int y, input bit with_vs);
    bit ha, va;
    logic [5:0] c;
    for (int p = 0; p < ht; p++) begin
      ha = (p < hsw) || (glitch && p == glitch_pos);
      va = with_vs && (y < vsw);
      c  = (y == cap_y && p == cap_px) ? cap_col : bg_col;
      @(negedge clk);
      ui_in = pins(ha, va, c);
    end
  endtask

  task automatic send_frame();
    for (int y = 0; y < vt; y++) send_line(y, 1'b1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    data_read_n = 2'b10;
    #1 d = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rv_t rv[8];
    tv_t tv[5];
    logic [31:0] d;
    logic [31:0] exp_glitch;

    rv[0] = '{6'h00, 32'h6}; rv[1] = '{6'h04, 32'h0}; rv[2] = '{6'h08, 32'h0};
    rv[3] = '{6'h0C, 32'h0}; rv[4] = '{6'h10, 32'h0}; rv[5] = '{6'h14, 32'h0};
    rv[6] = '{6'h18, 32'h0}; rv[7] = '{6'h3C, 32'h0};
    tv[0] = '{64,   8,   1'b0, 4'h3, 32'h0008_0040};
    tv[1] = '{1344, 136, 1'b0, 4'hF, 32'h0088_0540};
    tv[2] = '{1344, 136, 1'b1, 4'h9, 32'h0088_0540};
    tv[3] = '{1344, 136, 1'b1, 4'hF, 32'h04B8_0540};
    tv[4] = '{100,  20,  1'b0, 4'hF, 32'h0014_0064};
`ifdef VGA_CAP_GLITCH_FILTER_EN
    exp_glitch = 32'h0008_0040;
`else
    exp_glitch = 32'h0008_0018;
`endif

    rst_n = 1'b0;
    ui_in = pins(1'b0, 1'b0, bg_col);
    address = 6'h00;
    data_in = 32'd0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data_out", data_out, 32'd0);
    check("rst_irq", {31'd0, user_interrupt}, 32'd0);
    check("rst_uo_out", {24'd0, uo_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      rd(rv[i].addr, d);
      check($sformatf("reset_reg[%0h]", rv[i].addr), d, rv[i].exp);
    end
    check("data_ready", {31'd0, data_ready}, 32'd1);
    wr(6'h10, 32'hFFFF_FFFF);
    rd(6'h10, d);
    check("cap_pos_mask", d, 32'h07FF_0FFF);
    wr(6'h14, 32'hFFFF_FFFF);
    rd(6'h14, d);
    check("ro_capdata", d, 32'd0);

    for (int i = 0; i < 5; i++) begin
      ht = tv[i].ht; hsw = tv[i].hsw; pospol = tv[i].pos;
      wr(6'h00, {28'd0, tv[i].ctrl});
      for (int y = 5; y < 8; y++) send_line(y, 1'b0);
      rd(6'h08, d);
      check($sformatf("htime[%0d]", i), d, tv[i].exp);
    end

    // Lock, capture and interrupts on a 64x20 frame with 8-clock hsync and 2-line vsync.
    ht = 64; hsw = 8; pospol = 1'b0;
    do_reset();
    wr(6'h00, 32'hF);
    wr(6'h10, (32'd10 << 16) | 32'd30);
    cap_y = 10; cap_px = 31; cap_col = 6'h2A;
    send_frame();
    check("lock_no_irq", {31'd0, user_interrupt}, 32'd0);
    rd(6'h04, d);
    check("status_frameA", d, 32'h0000_0103);
    rd(6'h14, d);
    check("capdata_A", d, 32'h2A);

    cap_col = 6'h33;
    send_frame();
    check("irq_frameB", {31'd0, user_interrupt}, 32'd1);
    rd(6'h08, d);
    check("htime_B", d, 32'h0008_0040);
    rd(6'h0C, d);
    check("vtime_B", d, 32'h0002_0014);
    rd(6'h14, d);
    check("capdata_held", d, 32'h2A);
    rd(6'h04, d);
    check("status_frameB", d, 32'h0000_0207);
    check("irq_read_clear", {31'd0, user_interrupt}, 32'd0);

    wr(6'h04, 32'h2);
    send_frame();
    rd(6'h14, d);
    check("capdata_new", d, 32'h33);
    check("irq_frameC", {31'd0, user_interrupt}, 32'd1);
    wr(6'h04, 32'h4);
    check("irq_write_clear", {31'd0, user_interrupt}, 32'd0);
    rd(6'h04, d);
    check("status_frameC", d, 32'h0000_0303);
    wr(6'h10, (32'd10 << 16) | 32'd30);
    rd(6'h04, d);
    check("cappos_clears_valid", d, 32'h0000_0301);

    // Hsync loss: hcnt saturates at 4095 and drops lock, measurements retained.
    repeat (4100) @(negedge clk);
    rd(6'h04, d);
    check("timeout_unlock", d, 32'h0000_0300);
    rd(6'h0C, d);
    check("vtime_kept", d, 32'h0002_0014);
    for (int y = 5; y < vt; y++) send_line(y, 1'b1);
    rd(6'h04, d);
    check("seek_no_vs", d, 32'h0000_0300);
    send_frame();
    check("relock_no_irq", {31'd0, user_interrupt}, 32'd0);
    rd(6'h04, d);
    check("status_relock", d, 32'h0000_0403);

    // Positive sync with matching polarity, then mismatched polarity.
    wr(6'h00, 32'h9);
    pospol = 1'b1;
    send_frame();
    send_frame();
    rd(6'h08, d);
    check("htime_pos", d, 32'h0008_0040);
    rd(6'h0C, d);
    check("vtime_pos", d, 32'h0002_0014);
    wr(6'h00, 32'hF);
    send_frame();
    send_frame();
    rd(6'h08, d);
    check("htime_wrongpol", d, 32'h0038_0040);
    rd(6'h0C, d);
    check("vtime_wrongpol", d, 32'h0012_0014);

    // Single-clock hsync glitch at position 40 of one line.
    pospol = 1'b0;
    for (int y = 5; y < 8; y++) send_line(y, 1'b0);
    glitch = 1'b1;
    send_line(8, 1'b0);
    glitch = 1'b0;
    send_line(9, 1'b0);
    rd(6'h08, d);
    check("htime_glitch", d, exp_glitch);

    // Reset in the middle of a frame with an interrupt pending.
    rd(6'h04, d);
    for (int y = 0; y < 10; y++) send_line(y, 1'b1);
    check("irq_before_reset", {31'd0, user_interrupt}, 32'd1);
    address = 6'h00;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_irq", {31'd0, user_interrupt}, 32'd0);
    check("midrst_uo_out", {24'd0, uo_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(6'h00, d);
    check("post_rst_ctrl", d, 32'h6);
    rd(6'h04, d);
    check("post_rst_status", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
